// File: rtl/nx_ram_1r1w_fwd_if.sv
// nx_ram_1r1w_fwd_if - access bus for nx_ram_1r1w_fwd.
//   reb/ra       : read enable (active-low) and read address
//   web/wa/din   : write enable (active-low), write address, write data
//   bwe          : per-lane write enable, active-high
//   dout/dout_vld: read data and its valid strobe
//   wt_hit       : read result was forwarded from an uncommitted write
//   init_done    : initialisation finished, accesses accepted
//   access_err   : sticky error (access during init or address out of range)
interface nx_ram_1r1w_fwd_if #(
  parameter int unsigned WIDTH    = 83,
  parameter int unsigned AW       = 8,
  parameter int unsigned BWEWIDTH = 83
);
  logic                reb;
  logic [AW-1:0]       ra;
  logic [WIDTH-1:0]    dout;
  logic                dout_vld;
  logic                web;
  logic [AW-1:0]       wa;
  logic [WIDTH-1:0]    din;
  logic [BWEWIDTH-1:0] bwe;
  logic                init_done;
  logic                access_err;
  logic                wt_hit;

  modport master (
    output reb, ra, web, wa, din, bwe,
    input  dout, dout_vld, init_done, access_err, wt_hit
  );

  modport slave (
    input  reb, ra, web, wa, din, bwe,
    output dout, dout_vld, init_done, access_err, wt_hit
  );
endinterface

// File: rtl/nx_ram_1r1w_fwd.sv
// nx_ram_1r1w_fwd - single-clock 1R1W RAM with configurable read latency,
// lane write enables, write-through forwarding and reset-time initialisation.
//   clk  : clock
//   rst  : synchronous reset, active-high; restarts the init engine
//   bus  : nx_ram_1r1w_fwd_if slave modport (read/write ports, status)
// After rst drops, DEPTH edges write INIT_VALUE to every word; init_done then
// rises and read/write requests are accepted from the next edge on.
module nx_ram_1r1w_fwd #(
  parameter int unsigned      WIDTH        = 83,
  parameter int unsigned      DEPTH        = 168,
  parameter int unsigned      BWEWIDTH     = 83,
  parameter bit               IN_FLOP      = 1'b1,
  parameter int unsigned      RD_LATENCY   = 2,
  parameter bit               WRITETHROUGH = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0,
  localparam int unsigned     AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  nx_ram_1r1w_fwd_if.slave bus
);

  localparam int unsigned   LW       = WIDTH / BWEWIDTH;
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  if ((WIDTH % BWEWIDTH) != 0 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_param_chk
    $error("nx_ram_1r1w_fwd: illegal BWEWIDTH or RD_LATENCY");
  end

  typedef enum logic {S_INIT, S_READY} state_t;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0]    old_w,
                                             input logic [WIDTH-1:0]    new_w,
                                             input logic [BWEWIDTH-1:0] en);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BWEWIDTH; i++) m[i*LW +: LW] = {LW{en[i]}};
    return (new_w & m) | (old_w & ~m);
  endfunction

  logic [WIDTH-1:0]    mem [DEPTH];
  state_t              state;
  logic [AW-1:0]       init_ptr;
  logic                init_done_q;
  logic                access_err_q;

  logic                stg_vld;
  logic [AW-1:0]       stg_wa;
  logic [WIDTH-1:0]    stg_din;
  logic [BWEWIDTH-1:0] stg_bwe;

  logic [RD_LATENCY-1:0] pv;
  logic [RD_LATENCY-1:0] ph;
  logic [WIDTH-1:0]      pd [RD_LATENCY];

  logic                ready;
  logic                rd_req, wr_req, ra_ok, wa_ok, rd_acc, wr_acc;
  logic                cm_vld;
  logic [AW-1:0]       cm_wa;
  logic [WIDTH-1:0]    cm_din;
  logic [BWEWIDTH-1:0] cm_bwe;
  logic [WIDTH-1:0]    fwd_data;
  logic                fwd_hit;

  assign ready  = (state == S_READY);
  assign rd_req = ~bus.reb;
  assign wr_req = ~bus.web;
  assign ra_ok  = ({1'b0, bus.ra} < DEPTH_W);
  assign wa_ok  = ({1'b0, bus.wa} < DEPTH_W);
  assign rd_acc = ready & rd_req;
  assign wr_acc = ready & wr_req & wa_ok;

  // Write that lands in the array on this edge: the staged one when inputs
  // are flopped, otherwise the write being sampled right now.
  assign cm_vld = IN_FLOP ? stg_vld : wr_acc;
  assign cm_wa  = IN_FLOP ? stg_wa  : bus.wa;
  assign cm_din = IN_FLOP ? stg_din : bus.din;
  assign cm_bwe = IN_FLOP ? stg_bwe : bus.bwe;

  // Read result as the array will look once every write sampled up to this
  // edge has committed: older staged write first, then the same-edge write.
  always_comb begin
    fwd_data = '0;
    fwd_hit  = 1'b0;
    if (ra_ok) begin
      fwd_data = mem[bus.ra];
      if (WRITETHROUGH) begin
        if (IN_FLOP && stg_vld && stg_wa == bus.ra) begin
          fwd_data = merge(fwd_data, stg_din, stg_bwe);
          fwd_hit  = fwd_hit | (|stg_bwe);
        end
        if (wr_acc && bus.wa == bus.ra) begin
          fwd_data = merge(fwd_data, bus.din, bus.bwe);
          fwd_hit  = fwd_hit | (|bus.bwe);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) mem[init_ptr] <= INIT_VALUE;
      else if (cm_vld)     mem[cm_wa]    <= merge(mem[cm_wa], cm_din, cm_bwe);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      init_ptr     <= '0;
      init_done_q  <= 1'b0;
      access_err_q <= 1'b0;
      stg_vld      <= 1'b0;
      stg_wa       <= '0;
      stg_din      <= '0;
      stg_bwe      <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_PTR) begin
            state       <= S_READY;
            init_done_q <= 1'b1;
          end
          if (rd_req || wr_req) access_err_q <= 1'b1;
        end
        S_READY: begin
          if ((rd_req && !ra_ok) || (wr_req && !wa_ok)) access_err_q <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
      stg_vld <= IN_FLOP && wr_acc;
      if (IN_FLOP && wr_acc) begin
        stg_wa  <= bus.wa;
        stg_din <= bus.din;
        stg_bwe <= bus.bwe;
      end
    end
  end

  // Data stages load only behind a valid, so dout holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      ph <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      ph[0] <= rd_acc & fwd_hit;
      if (rd_acc) pd[0] <= fwd_data;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        ph[i] <= ph[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign bus.dout       = pd[RD_LATENCY-1];
  assign bus.dout_vld   = pv[RD_LATENCY-1];
  assign bus.wt_hit     = ph[RD_LATENCY-1];
  assign bus.init_done  = init_done_q;
  assign bus.access_err = access_err_q;

endmodule

// File: tb/tb_nx_ram_1r1w_fwd.sv
// tb_nx_ram_1r1w_fwd - directed self-checking bench driving four RAM instances
// with shared stimulus:
//   u0: RD_LATENCY=1 IN_FLOP=1 WRITETHROUGH=1
//   u1: RD_LATENCY=2 IN_FLOP=1 WRITETHROUGH=1
//   u2: RD_LATENCY=3 IN_FLOP=1 WRITETHROUGH=0
//   u3: RD_LATENCY=4 IN_FLOP=0 WRITETHROUGH=1
// Every cycle each instance's dout_vld/wt_hit/dout is checked against a
// schedule of expected read results placed RD_LATENCY-1 edges after sampling.
module tb_nx_ram_1r1w_fwd;
  localparam int unsigned W  = 83;
  localparam int unsigned D  = 168;
  localparam int unsigned AW = 8;
  localparam int unsigned NB = 83;

  logic clk;
  logic rst;
  logic reb, web;
  logic [AW-1:0] ra, wa;
  logic [W-1:0]  din;
  logic [NB-1:0] bwe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nx_ram_1r1w_fwd_if #(.WIDTH(W), .AW(AW), .BWEWIDTH(NB)) if0 (), if1 (), if2 (), if3 ();

  assign if0.reb = reb; assign if0.ra = ra; assign if0.web = web; assign if0.wa = wa; assign if0.din = din; assign if0.bwe = bwe;
  assign if1.reb = reb; assign if1.ra = ra; assign if1.web = web; assign if1.wa = wa; assign if1.din = din; assign if1.bwe = bwe;
  assign if2.reb = reb; assign if2.ra = ra; assign if2.web = web; assign if2.wa = wa; assign if2.din = din; assign if2.bwe = bwe;
  assign if3.reb = reb; assign if3.ra = ra; assign if3.web = web; assign if3.wa = wa; assign if3.din = din; assign if3.bwe = bwe;

  nx_ram_1r1w_fwd #(.WIDTH(W), .DEPTH(D), .BWEWIDTH(NB), .IN_FLOP(1'b1), .RD_LATENCY(1),
                    .WRITETHROUGH(1'b1), .INIT_VALUE('0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  nx_ram_1r1w_fwd #(.WIDTH(W), .DEPTH(D), .BWEWIDTH(NB), .IN_FLOP(1'b1), .RD_LATENCY(2),
                    .WRITETHROUGH(1'b1), .INIT_VALUE('0)) u1 (.clk(clk), .rst(rst), .bus(if1));
  nx_ram_1r1w_fwd #(.WIDTH(W), .DEPTH(D), .BWEWIDTH(NB), .IN_FLOP(1'b1), .RD_LATENCY(3),
                    .WRITETHROUGH(1'b0), .INIT_VALUE('0)) u2 (.clk(clk), .rst(rst), .bus(if2));
  nx_ram_1r1w_fwd #(.WIDTH(W), .DEPTH(D), .BWEWIDTH(NB), .IN_FLOP(1'b0), .RD_LATENCY(4),
                    .WRITETHROUGH(1'b1), .INIT_VALUE('0)) u3 (.clk(clk), .rst(rst), .bus(if3));

  logic [W-1:0] o_dout [4];
  logic         o_vld [4], o_hit [4], o_done [4], o_err [4];
  assign o_dout[0] = if0.dout; assign o_vld[0] = if0.dout_vld; assign o_hit[0] = if0.wt_hit; assign o_done[0] = if0.init_done; assign o_err[0] = if0.access_err;
  assign o_dout[1] = if1.dout; assign o_vld[1] = if1.dout_vld; assign o_hit[1] = if1.wt_hit; assign o_done[1] = if1.init_done; assign o_err[1] = if1.access_err;
  assign o_dout[2] = if2.dout; assign o_vld[2] = if2.dout_vld; assign o_hit[2] = if2.wt_hit; assign o_done[2] = if2.init_done; assign o_err[2] = if2.access_err;
  assign o_dout[3] = if3.dout; assign o_vld[3] = if3.dout_vld; assign o_hit[3] = if3.wt_hit; assign o_done[3] = if3.init_done; assign o_err[3] = if3.access_err;

  int           n_chk, n_fail, cyc;
  logic         s_vld [4][64];
  logic         s_hit [4][64];
  logic [W-1:0] s_dat [4][64];
  logic [W-1:0] last  [4];
  logic [W-1:0] ex_d  [4];
  logic         ex_h  [4];
  logic [W-1:0] mdl   [D];

  function automatic int lat(input int d);
    return d + 1;
  endfunction

  function automatic bit wt(input int d);
    return d != 2;
  endfunction

  task automatic chk(input int d, input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d] cycle %0d: observed %h expected %h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc % 64;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        for (int j = 0; j < 64; j++) s_vld[d][j] = 1'b0;
        last[d] = '0;
      end
      chk(d, "dout_vld", W'(o_vld[d]), W'(s_vld[d][k]));
      chk(d, "wt_hit", W'(o_hit[d]), s_vld[d][k] ? W'(s_hit[d][k]) : '0);
      if (s_vld[d][k]) begin
        chk(d, "dout", o_dout[d], s_dat[d][k]);
        last[d] = s_dat[d][k];
      end else begin
        chk(d, "dout_hold", o_dout[d], last[d]);
      end
      s_vld[d][k] = 1'b0;
    end
  endtask

  task automatic idle();
    reb = 1'b1;
    web = 1'b1;
    bwe = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] data, input logic [NB-1:0] m);
    web = 1'b0; wa = a; din = data; bwe = m;
    if (a < D) mdl[a] = (data & m) | (mdl[a] & ~m);
  endtask

  task automatic exp_all(input logic [W-1:0] v, input logic h);
    for (int d = 0; d < 4; d++) begin ex_d[d] = v; ex_h[d] = h; end
  endtask

  task automatic exp_wt(input logic [W-1:0] fwd, input logic h, input logic [W-1:0] raw);
    for (int d = 0; d < 4; d++) begin
      ex_d[d] = wt(d) ? fwd : raw;
      ex_h[d] = wt(d) ? h : 1'b0;
    end
  endtask

  task automatic rd(input logic [AW-1:0] a);
    int s;
    reb = 1'b0; ra = a;
    for (int d = 0; d < 4; d++) begin
      s = (cyc + lat(d)) % 64;
      s_vld[d][s] = 1'b1; s_dat[d][s] = ex_d[d]; s_hit[d][s] = ex_h[d];
    end
  endtask

  task automatic status(input string tag, input logic done, input logic err);
    for (int d = 0; d < 4; d++) begin
      chk(d, {tag, "_init_done"}, W'(o_done[d]), W'(done));
      chk(d, {tag, "_access_err"}, W'(o_err[d]), W'(err));
    end
  endtask

  logic [W-1:0]  lane_exp, val_a, val_b, val_c;
  logic [NB-1:0] low41, half;
  logic [AW-1:0] a;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < 4; d++) begin
      last[d] = '0;
      for (int j = 0; j < 64; j++) s_vld[d][j] = 1'b0;
    end
    for (int i = 0; i < D; i++) mdl[i] = '0;
    lane_exp = {42'h3FF_FFFF_FFFF, 41'h0};
    low41    = 83'h1FF_FFFF_FFFF;
    half     = 83'h2_AAAA_AAAA_AAAA_AAAA_AAAA;
    val_a    = 83'h5_5555_5555_5555_5555_5555;
    val_b    = 83'h3_0F0F_1234_89AB_CDEF_0F0F;
    val_c    = 83'h0_DEAD_BEEF_0000_CAFE_F00D;
    ra = '0; wa = '0; din = '0;
    idle();

    // Reset, then init with one illegal read at edge 100
    rst = 1'b1;
    repeat (3) step();
    status("reset", 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= int'(D); k++) begin
      idle();
      if (k == 100) begin reb = 1'b0; ra = '0; end
      step();
      status("init", k == int'(D), k >= 100);
    end
    idle();

    // Reset again to clear the error, clean init, then first accesses
    rst = 1'b1;
    repeat (2) step();
    status("rst2", 1'b0, 1'b0);
    rst = 1'b0;
    repeat (D - 1) step();
    status("init2_pre", 1'b0, 1'b0);
    step();
    status("init2_done", 1'b1, 1'b0);
    exp_all('0, 1'b0); rd(8'd0);   step();
    exp_all('0, 1'b0); rd(8'd167); step();
    idle(); repeat (4) step();

    // Lane merge
    wr(8'd5, '1, '1);       step();
    idle(); wr(8'd5, '0, low41); step();
    idle(); repeat (2) step();
    exp_all(lane_exp, 1'b0); rd(8'd5); step();
    idle(); repeat (4) step();

    // Same-edge collision
    wr(8'd9, 83'h1234, '1); exp_wt(83'h1234, 1'b1, '0); rd(8'd9); step();
    idle(); repeat (2) step();
    // Zero-lane write to the read address: no data change, no hit
    wr(8'd9, '1, '0); exp_all(83'h1234, 1'b0); rd(8'd9); step();
    idle(); repeat (4) step();

    // Read one edge after a write: staged forward vs committed vs raw
    wr(8'd30, val_c, '1); step();
    idle();
    ex_d[0] = val_c; ex_h[0] = 1'b1;
    ex_d[1] = val_c; ex_h[1] = 1'b1;
    ex_d[2] = '0;    ex_h[2] = 1'b0;
    ex_d[3] = val_c; ex_h[3] = 1'b0;
    rd(8'd30); step();
    idle(); repeat (4) step();

    // Back-to-back writes to one address, read with the second
    wr(8'd20, val_a, '1); step();
    idle(); wr(8'd20, val_b, half); exp_wt(mdl[20], 1'b1, '0); rd(8'd20); step();
    idle(); step();
    exp_all(mdl[20], 1'b0); rd(8'd20); step();
    idle(); repeat (4) step();

    // Full-rate read stream
    for (int i = 0; i < 200; i++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: a = 8'd5;
          1: a = 8'd9;
          2: a = 8'd20;
          3: a = 8'd30;
          default: a = AW'($urandom_range(0, D - 1));
        endcase
        exp_all(mdl[a], 1'b0); rd(a);
      end
      step();
    end
    idle(); repeat (4) step();

    // Out-of-range accesses
    status("pre_err", 1'b1, 1'b0);
    wr(8'd200, '1, '1); step();
    status("wa_oor", 1'b1, 1'b1);
    idle(); exp_all(lane_exp, 1'b0); rd(8'd5);   step();
    exp_all('0, 1'b0);               rd(8'd170); step();
    idle(); repeat (4) step();

    // Reset mid-stream with reads in flight
    exp_all(lane_exp, 1'b0); rd(8'd5); step();
    exp_all(lane_exp, 1'b0); rd(8'd5); step();
    reb = 1'b0; ra = 8'd5; rst = 1'b1; step();
    status("mid_rst", 1'b0, 1'b0);
    idle(); web = 1'b0; wa = 8'd9; din = '1; bwe = '1; step();
    idle(); rst = 1'b0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    repeat (D - 1) step();
    status("reinit_pre", 1'b0, 1'b0);
    step();
    status("reinit_done", 1'b1, 1'b0);
    exp_all('0, 1'b0); rd(8'd9); step();
    exp_all('0, 1'b0); rd(8'd5); step();
    idle(); repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_ram_1r1w_fwd.md
# nx_ram_1r1w_fwd

Parametrised single-clock 1R1W RAM for the nx_library. It adds the following over the fixed-latency nx_ram_1r1w:
- configurable read latency (1–4)
- lane-granular write enables
- full write-through forwarding across the staged write path
- a reset-triggered memory initialisation engine
- a read-valid pipeline and access-error flag

It is the drop-in RAM for engine FIFOs and history buffers where read-after-write within a cycle must return new data.

## Interface
- WIDTH, 83, data width in bits
- DEPTH, 168, number of words; AW = $clog2(DEPTH)
- BWEWIDTH, 83, write-enable lanes; must divide WIDTH; lane i covers bits [i*L +: L], L = WIDTH/BWEWIDTH
- IN_FLOP, 1, 1 = register web/wa/din/bwe one cycle before commit; 0 = commit at sampling edge
- RD_LATENCY, 2, 1..4 edges from read sample to dout
- WRITETHROUGH, 1, 1 = forward same-edge and staged writes to reads; 0 = raw array read
- INIT_VALUE, {WIDTH{1'b0}}, value written to every word after reset
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- reb  in  1  read enable, active-low
- ra  in  AW  read address
- dout  out  WIDTH  read data
- dout_vld  out  1  dout carries a new read result this cycle
- web  in  1  write enable, active-low
- wa  in  AW  write address
- din  in  WIDTH  write data
- bwe  in  BWEWIDTH  per-lane write enable, active-high
- init_done  out  1  initialisation complete; accesses accepted
- access_err  out  1  sticky: access during init or address ≥ DEPTH
- wt_hit  out  1  aligned with dout_vld; result was forwarded from a not-yet-committed write

## Operation
- **Reset values** (any edge with rst=1):
  - dout=0, dout_vld=0, init_done=0, access_err=0, wt_hit=0
  - staged write and read pipeline discarded; init pointer=0
  - FSM enters INIT
- **FSM: INIT → READY.**
  - INIT: each edge with rst=0 writes INIT_VALUE to mem[ptr] and increments ptr.
  - At the edge writing DEPTH-1, go to READY and set init_done=1.
  - READY persists until rst.
- **Requests during INIT** (reb=0 or web=0): ignored, no dout_vld, access_err set.
- **Write merge:** mem[wa] lane i ← din lane i where bwe[i]=1, else the old lane. bwe=0 with web=0 is a legal no-op.
- **Commit timing:** a write sampled at edge t commits at edge t+IN_FLOP.
- **Read:** sampled at edge t with reb=0. Result is captured at t, delayed RD_LATENCY-1 register stages, and presented with dout_vld=1.
  - dout holds its last value while dout_vld=0.
- **WRITETHROUGH=1:** the read result equals the array after all writes sampled at edges ≤ t.
  - Staged (older) write is applied, then same-edge (newer) write; newer lane wins.
  - wt_hit=1 if either applied write matched ra with a nonzero bwe.
- **WRITETHROUGH=0:** result is the raw array at t; same-edge or staged writes are not visible; wt_hit=0 always.
- **Out-of-range address:**
  - wa ≥ DEPTH: write dropped, access_err set.
  - ra ≥ DEPTH: dout=0 with dout_vld=1, access_err set.
- **access_err** clears only on rst.

## Timing
- Read latency is exactly RD_LATENCY edges.
  - Read sampled at edge t is visible after edge t+RD_LATENCY-1; RD_LATENCY=1 means visible right after the sampling edge.
- Full throughput: one read and one write per cycle, no back-pressure, no bubbles.
- Init takes DEPTH edges after rst deasserts; init_done rises after the DEPTH-th edge. The first accepted access is on the following edge.
- **Reset mid-operation:**
  - In-flight reads are dropped (dout_vld=0 from the reset edge).
  - Staged write is discarded; a write sampled on an edge with rst=1 is not performed.
  - Contents are re-initialised.

## Test plan
- **Init:** DEPTH=168, INIT_VALUE=0, rst high 3 cycles then low.
  - init_done rises after edge 168.
  - Reads of addr 0 and 167 return 0 with dout_vld exactly RD_LATENCY edges later.
  - A read at edge 100 is ignored and sets access_err.
- **Lane merge:** BWEWIDTH=83, write mem[5]=all-ones, then write din=0 with bwe bits [40:0] only.
  - Read of 5 returns {42'h3FF_FFFF_FFFF, 41'h0}.
- **Same-edge collision, IN_FLOP=1:** write 0x1234 to addr 9 and read 9 at the same edge.
  - WRITETHROUGH=1: dout=0x1234, wt_hit=1.
  - WRITETHROUGH=0: dout is the old value (0), wt_hit=0.
- **Back-to-back same address:** write A at edge t, write B to the same address at t+1 (half lanes), read at t+1.
  - Result = B on enabled lanes, A elsewhere.
  - A read of the same address at t+3 returns the same value with wt_hit=0.
- **Latency sweep RD_LATENCY=1..4:** stream 200 reads at full rate.
  - dout_vld pattern equals the reb pattern delayed by RD_LATENCY; data matches the model.
- **Errors and reset:**
  - wa=200: write dropped, access_err=1.
  - ra=170: dout_vld=1 with dout=0.
  - Assert rst mid-stream: dout_vld=0 immediately, access_err=0, re-init completes in 168 edges.
